// File: rtl/vga_capture_if.sv
// Greyscale VGA sink link: sampled video/sync inputs, framebuffer write
// port and frame status flags.
interface vga_capture_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 19
);
  logic              pix_en;
  logic              hsync;
  logic              vsync;
  logic              blank_b;
  logic [DATA_W-1:0] video_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              frame_done;
  logic              locked;
  logic              err;

  modport master (
    output pix_en,
    output hsync,
    output vsync,
    output blank_b,
    output video_data,
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    input  frame_done,
    input  locked,
    input  err
  );

  modport slave (
    input  pix_en,
    input  hsync,
    input  vsync,
    input  blank_b,
    input  video_data,
    output wr_en,
    output wr_addr,
    output wr_data,
    output frame_done,
    output locked,
    output err
  );
endinterface

// File: rtl/vga_capture.sv
// Greyscale VGA capture: rebuilds pixel coordinates from sync/blank,
// writes active pixels to a framebuffer and tracks timing lock.
module vga_capture #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 19,
  parameter int LOCK_FRAMES = 2
) (
  input  logic          clk,
  input  logic          reset,
  vga_capture_if.slave  vif
);

  localparam int XW = $clog2(H_ACTIVE + 2) + 1;
  localparam int YW = $clog2(V_ACTIVE + 2) + 1;
  localparam int GW = $clog2(LOCK_FRAMES + 1);

  localparam logic [XW-1:0]     X_END     = XW'(H_ACTIVE);
  localparam logic [YW-1:0]     Y_END     = YW'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACTIVE);
  localparam logic [GW-1:0]     G_LOCK    = GW'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    IDLE,
    VSYNC,
    CAPTURE
  } state_t;

  state_t state;

  logic              s_vld;
  logic              s_vsync;
  logic              p_vsync;
  logic              s_blank;
  logic              p_blank;
  logic [DATA_W-1:0] s_data;

  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] base;
  logic              bad;
  logic [GW-1:0]     gcnt;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              frame_done;
  logic              locked;
  logic              err;

  logic              vfall;
  logic              vrise;
  logic              bfall;
  logic              eol;
  logic              line_bad;
  logic              frame_bad;
  logic              in_range;
  logic [XW-1:0]     x_inc;
  logic [YW-1:0]     y_inc;
  logic [YW-1:0]     y_nxt;
  logic [ADDR_W-1:0] base_nxt;
  logic [GW-1:0]     g_inc;

  // Current and previous sample; edges are seen on the sample that changes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s_vld   <= 1'b0;
      s_vsync <= 1'b0;
      p_vsync <= 1'b0;
      s_blank <= 1'b0;
      p_blank <= 1'b0;
      s_data  <= '0;
    end else begin
      s_vld <= vif.pix_en;
      if (vif.pix_en) begin
        p_vsync <= s_vsync;
        s_vsync <= vif.vsync;
        p_blank <= s_blank;
        s_blank <= vif.blank_b;
        s_data  <= vif.video_data;
      end
    end
  end

  always_comb begin
    vfall     = p_vsync & ~s_vsync;
    vrise     = ~p_vsync & s_vsync;
    bfall     = p_blank & ~s_blank;
    eol       = bfall && (x != '0);
    line_bad  = eol && (x != X_END);
    x_inc     = (x == '1) ? x : x + 1'b1;
    y_inc     = (y == '1) ? y : y + 1'b1;
    y_nxt     = eol ? y_inc : y;
    base_nxt  = base + LINE_STEP;
    frame_bad = (y_nxt != Y_END) || bad || line_bad;
    g_inc     = (gcnt >= G_LOCK) ? gcnt : gcnt + 1'b1;
    in_range  = (x < X_END) && (y < Y_END);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      x          <= '0;
      y          <= '0;
      addr       <= '0;
      base       <= '0;
      bad        <= 1'b0;
      gcnt       <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      locked     <= 1'b0;
      err        <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
      if (s_vld) begin
        unique case (state)
          IDLE: begin
            if (vfall) state <= VSYNC;
          end
          VSYNC: begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
            base <= '0;
            bad  <= 1'b0;
            if (vrise) state <= CAPTURE;
          end
          CAPTURE: begin
            if (s_blank) begin
              if (in_range) begin
                wr_en   <= 1'b1;
                wr_addr <= addr;
                wr_data <= s_data;
              end
              x    <= x_inc;
              addr <= addr + 1'b1;
            end else if (eol) begin
              x    <= '0;
              y    <= y_inc;
              base <= base_nxt;
              addr <= base_nxt;
              if (line_bad) begin
                bad <= 1'b1;
                err <= 1'b1;
              end
            end
            // Line check above folds into frame_bad, so one err pulse max.
            if (vfall) begin
              frame_done <= 1'b1;
              state      <= VSYNC;
              if (frame_bad) begin
                err    <= 1'b1;
                gcnt   <= '0;
                locked <= 1'b0;
              end else begin
                gcnt   <= g_inc;
                locked <= (g_inc >= G_LOCK);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign vif.wr_en      = wr_en;
  assign vif.wr_addr    = wr_addr;
  assign vif.wr_data    = wr_data;
  assign vif.frame_done = frame_done;
  assign vif.locked     = locked;
  assign vif.err        = err;

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture: scoreboarded framebuffer writes,
// frame/lock/error status on an 8x4 frame.
module tb_vga_capture;
  localparam int H  = 8;
  localparam int V  = 4;
  localparam int DW = 8;
  localparam int AW = 19;
  localparam int LF = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  vga_capture_if #(.DATA_W(DW), .ADDR_W(AW)) vif ();

  vga_capture #(
    .H_ACTIVE(H),
    .V_ACTIVE(V),
    .DATA_W(DW),
    .ADDR_W(AW),
    .LOCK_FRAMES(LF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .vif(vif)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t q[$];
  wr_t e;
  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int fd_cnt = 0;
  int err_cnt = 0;
  logic fd_lock = 1'b0;
  logic fd_err = 1'b0;
  logic [1:0] ph = 2'b00;
  int w0, f0, e0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) ph <= {ph[0], vif.pix_en};

  always @(negedge clk) begin
    if (vif.wr_en === 1'b1) begin
      wr_cnt++;
      chk("wr_strobe_lag", {31'b0, ph[1]}, 32'd1);
      chk("wr_pending", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("wr_addr", 32'(vif.wr_addr), 32'(e.addr));
        chk("wr_data", 32'(vif.wr_data), 32'(e.data));
      end
    end
    if (vif.frame_done === 1'b1) begin
      fd_cnt++;
      fd_lock = vif.locked;
      fd_err  = vif.err;
    end
    if (vif.err === 1'b1) err_cnt++;
  end

  task automatic smp(logic vs, logic bl, logic [7:0] d, int step);
    @(negedge clk);
    vif.pix_en     = 1'b1;
    vif.vsync      = vs;
    vif.hsync      = bl | vs;
    vif.blank_b    = bl;
    vif.video_data = d;
    repeat (step - 1) begin
      @(negedge clk);
      vif.pix_en = 1'b0;
    end
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      vif.pix_en = 1'b0;
    end
  endtask

  task automatic vs_fall(int step);
    smp(1'b0, 1'b0, 8'd0, step);
    smp(1'b0, 1'b0, 8'd0, step);
  endtask

  task automatic body(int lines, int long_line, int step);
    smp(1'b1, 1'b0, 8'd0, step);
    smp(1'b1, 1'b0, 8'd0, step);
    for (int l = 0; l < lines; l++) begin
      smp(1'b1, 1'b0, 8'd0, step);
      smp(1'b1, 1'b0, 8'd0, step);
      for (int x = 0; x < ((l == long_line) ? H + 1 : H); x++) begin
        wr_t w;
        w.addr = AW'(l * H + x);
        w.data = DW'(x + 16 * l);
        if (x < H && l < V) q.push_back(w);
        smp(1'b1, 1'b1, w.data, step);
      end
    end
    smp(1'b1, 1'b0, 8'd0, step);
    smp(1'b1, 1'b0, 8'd0, step);
  endtask

  task automatic frame(int lines, int long_line, int step);
    w0 = wr_cnt;
    f0 = fd_cnt;
    e0 = err_cnt;
    body(lines, long_line, step);
    vs_fall(step);
    idle(6);
  endtask

  initial begin
    vif.pix_en = 1'b0;
    vif.hsync = 1'b1;
    vif.vsync = 1'b1;
    vif.blank_b = 1'b0;
    vif.video_data = '0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Test 1: partial frame, then reset mid-capture
    smp(1'b1, 1'b0, 8'd0, 1);
    vs_fall(1);
    body(2, -1, 1);
    for (int x = 0; x < 3; x++) begin
      wr_t w;
      w.addr = AW'(2 * H + x);
      w.data = DW'(x + 32);
      q.push_back(w);
      smp(1'b1, 1'b1, w.data, 1);
    end
    idle(4);
    chk("t1_partial_writes", wr_cnt, 32'd19);
    chk("t1_queue_drained", q.size(), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    vif.pix_en = 1'b1;
    @(negedge clk);
    chk("t1_rst_wr_en", {31'b0, vif.wr_en}, 32'd0);
    chk("t1_rst_wr_addr", 32'(vif.wr_addr), 32'd0);
    chk("t1_rst_wr_data", 32'(vif.wr_data), 32'd0);
    chk("t1_rst_frame_done", {31'b0, vif.frame_done}, 32'd0);
    chk("t1_rst_locked", {31'b0, vif.locked}, 32'd0);
    chk("t1_rst_err", {31'b0, vif.err}, 32'd0);
    reset = 1'b1;
    vif.pix_en = 1'b0;
    w0 = wr_cnt;
    for (int i = 0; i < 4; i++) smp(1'b1, 1'b1, 8'(i + 100), 1);
    vs_fall(1);
    for (int i = 0; i < 3; i++) smp(1'b0, 1'b1, 8'(i + 200), 1);
    idle(4);
    chk("t1_no_wr_before_rise", wr_cnt - w0, 32'd0);
    chk("t1_no_frame_done", fd_cnt, 32'd0);
    chk("t1_no_err", err_cnt, 32'd0);

    // Test 2: clean frame
    frame(4, -1, 1);
    chk("t2_writes", wr_cnt - w0, 32'd32);
    chk("t2_frame_done", fd_cnt - f0, 32'd1);
    chk("t2_err", err_cnt - e0, 32'd0);
    chk("t2_queue", q.size(), 32'd0);
    chk("t2_locked_f1", {31'b0, fd_lock}, 32'd0);

    // Test 3: second clean frame locks
    frame(4, -1, 1);
    chk("t3_writes", wr_cnt - w0, 32'd32);
    chk("t3_err", err_cnt - e0, 32'd0);
    chk("t3_locked_f2", {31'b0, fd_lock}, 32'd1);

    // Test 4: one 9-pixel line, then relock
    frame(4, 1, 1);
    chk("t4_writes", wr_cnt - w0, 32'd32);
    chk("t4_err_pulses", err_cnt - e0, 32'd2);
    chk("t4_err_at_fd", {31'b0, fd_err}, 32'd1);
    chk("t4_unlocked", {31'b0, fd_lock}, 32'd0);
    chk("t4_queue", q.size(), 32'd0);
    frame(4, -1, 1);
    chk("t4_relock1", {31'b0, fd_lock}, 32'd0);
    chk("t4_relock1_err", err_cnt - e0, 32'd0);
    frame(4, -1, 1);
    chk("t4_relock2", {31'b0, fd_lock}, 32'd1);

    // Test 5: short frame
    frame(3, -1, 1);
    chk("t5_writes", wr_cnt - w0, 32'd24);
    chk("t5_frame_done", fd_cnt - f0, 32'd1);
    chk("t5_err_at_fd", {31'b0, fd_err}, 32'd1);
    chk("t5_err_pulses", err_cnt - e0, 32'd1);
    chk("t5_unlocked", {31'b0, fd_lock}, 32'd0);

    // Test 6: strobe every 4th clock
    frame(4, -1, 4);
    chk("t6_writes", wr_cnt - w0, 32'd32);
    chk("t6_frame_done", fd_cnt - f0, 32'd1);
    chk("t6_err", err_cnt - e0, 32'd0);
    chk("t6_queue", q.size(), 32'd0);
    chk("t6_locked", {31'b0, fd_lock}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
